alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (e.g. main datapath, branch/addr unit).

---
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one op in flight (IDLE->EXEC->RESP).
// Latency: accept in cycle N, response valid in N+2; backpressure: RESP holds until owner's rsp_ready_i.
// Optional ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   src1_q, src2_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                owner_q;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q;
    logic                gnt;
    logic                accept;
`ifndef ARB_FIXED_PRIO_EN
    logic                last_gnt_q;
`endif

    // Single requester always wins; on contention pick by policy.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        gnt = 1'b0;
`else
        gnt = ~last_gnt_q;
`endif
        if (req_valid_i == 2'b01) begin
            gnt = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            gnt = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 2'b00;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i[gnt]) begin
                    req_ready_o[gnt] = 1'b1;
                    accept           = 1'b1;
                    state_d          = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= '0;
            owner_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                src1_q     <= gnt ? req1_src1_i : req0_src1_i;
                src2_q     <= gnt ? req1_src2_i : req0_src2_i;
                ctrl_q     <= gnt ? req1_ctrl_i : req0_ctrl_i;
                owner_q    <= gnt;
`ifndef ARB_FIXED_PRIO_EN
                last_gnt_q <= gnt;
`endif
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result_i;
                zero_q   <= alu_zero_i;
            end
        end
    end

    // ALU only ever sees the operand registers, so it holds the last op when idle.
    assign alu_src1_o   = src1_q;
    assign alu_src2_o   = src2_q;
    assign alu_ctrl_o   = ctrl_q;
    assign rsp_valid_o  = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0] r0_s1, r0_s2, r1_s1, r1_s2;
    logic [CW-1:0] r0_c, r1_c;
    logic [DW-1:0] alu_src1, alu_src2, alu_result, rsp_result;
    logic [CW-1:0] alu_ctrl;
    logic          alu_zero, rsp_zero, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req0_src1_i(r0_s1), .req0_src2_i(r0_s2), .req0_ctrl_i(r0_c),
        .req1_src1_i(r1_s1), .req1_src2_i(r1_s2), .req1_ctrl_i(r1_c),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .busy_o(busy)
    );

    function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [CW-1:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_src1, alu_src2, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    function automatic bit win(logic [1:0] v, bit last);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return !last;
`endif
    endfunction

    // Transaction model: an op is "in flight" from accept; age>=2 means response offered.
    bit            m_known = 0, m_infl = 0, m_owner = 0, m_last = 1, m_g;
    int            m_age = 0;
    logic [DW-1:0] m_s1 = '0, m_s2 = '0, m_res = '0;
    logic [CW-1:0] m_c = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_known = 1; m_infl = 0; m_age = 0; m_last = 1;
            m_s1 = '0; m_s2 = '0; m_c = '0; m_res = '0;
        end else if (m_known) begin
            if (!m_infl) begin
                if (req_valid != 2'b00) begin
                    m_g     = win(req_valid, m_last);
                    m_infl  = 1; m_age = 1; m_owner = m_g; m_last = m_g;
                    m_s1    = m_g ? r1_s1 : r0_s1;
                    m_s2    = m_g ? r1_s2 : r0_s2;
                    m_c     = m_g ? r1_c  : r0_c;
                    m_res   = alu_f(m_s1, m_s2, m_c);
                end
            end else if (m_age >= 2 && rsp_ready[m_owner]) begin
                m_infl = 0;
            end else if (m_age < 2) begin
                m_age++;
            end
        end
    end

    int gq_idx[$];
    int gq_cyc[$];

    always @(negedge clk) begin
        logic [1:0] e_rdy, e_vld;
        if (m_known) begin
            e_rdy = (!m_infl && req_valid != 2'b00) ? (win(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00;
            e_vld = (m_infl && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            check("m_req_ready", req_ready, e_rdy);
            check("m_rsp_valid", rsp_valid, e_vld);
            check("m_busy", busy, m_infl);
            check("m_alu_src1", alu_src1, m_s1);
            check("m_alu_src2", alu_src2, m_s2);
            check("m_alu_ctrl", alu_ctrl, m_c);
            if (e_vld != 2'b00) begin
                check("m_rsp_result", rsp_result, m_res);
                check("m_rsp_zero", rsp_zero, m_res == '0);
            end
            if (req_ready != 2'b00) begin
                gq_idx.push_back(req_ready[1] ? 1 : 0);
                gq_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
        if (k == 0) begin r0_s1 = a; r0_s2 = b; r0_c = c; end
        else        begin r1_s1 = a; r1_s2 = b; r1_c = c; end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
        ok = req_ready[k];
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic do_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c,
                         output logic [DW-1:0] res, output logic z, output int lat);
        bit ok;
        int c0, n;
        @(posedge clk); #1;
        set_req(k, a, b, c);
        req_valid = (k == 1) ? 2'b10 : 2'b01;
        wait_ready(k, ok);
        c0 = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[k] && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid[k]) check("rsp_timeout", 0, 1);
        lat = cyc - c0; res = rsp_result; z = rsp_zero;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] res, r0;
        logic          z;
        int            lat, n, seen;
        bit            ok;
        logic [3:0]    exp_g;

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_alu_src1", alu_src1, 0);
        check("rst_req_ready", req_ready, 0);

        do_op(0, 5, 7, 4'b0010, res, z, lat);
        check("add_result", res, 12);
        check("add_zero", z, 0);
        check("add_latency", lat, 2);

        do_op(1, 3, 3, 4'b0110, res, z, lat);
        check("sub_result", res, 0);
        check("sub_zero", z, 1);
        check("sub_latency", lat, 2);

        // Contention from reset.
        do_reset();
        gq_idx.delete(); gq_cyc.delete();
        set_req(0, 1, 1, 4'b0010); set_req(1, 5, 3, 4'b0000);
        req_valid = 2'b11;
        repeat (13) @(posedge clk);
        #1 req_valid = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
        exp_g = 4'b0000;
`else
        exp_g = 4'b1010;
`endif
        check("grant_count_ge4", gq_idx.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq_idx.size()) check("grant_seq", gq_idx[i], exp_g[i]);
        end
        repeat (4) @(posedge clk);

        // Response stall with competing requester.
        #1 rsp_ready = 2'b00;
        set_req(0, 9, 4, 4'b0001); set_req(1, 2, 2, 4'b0010);
        req_valid = 2'b01;
        wait_ready(0, ok);
        @(posedge clk); #1 req_valid = 2'b10;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
        r0 = rsp_result;
        check("stall_result", r0, 13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 2'b01);
            check("stall_result_hold", rsp_result, r0);
            check("stall_req_ready", req_ready, 2'b00);
            check("stall_busy", busy, 1);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        repeat (6) @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // Reset while in EXEC discards the op.
        #1 set_req(0, 1, 2, 4'b0010);
        req_valid = 2'b01;
        wait_ready(0, ok);
        @(posedge clk); #1 req_valid = 2'b00; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstx_busy", busy, 0);
        check("rstx_rsp_valid", rsp_valid, 0);
        check("rstx_alu_src1", alu_src1, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
        end
        check("rstx_no_response", seen, 0);

        // Back-to-back SLT from requester 1.
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        set_req(1, 1, 2, 4'b0111);
        gq_idx.delete(); gq_cyc.delete();
        req_valid = 2'b10;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                seen++;
                check("slt_result", rsp_result, 1);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        check("slt_seen", seen > 0, 1);
        check("slt_grants_ge3", gq_idx.size() >= 3, 1);
        if (gq_idx.size() >= 3) begin
            check("slt_interval0", gq_cyc[1] - gq_cyc[0], 3);
            check("slt_interval1", gq_cyc[2] - gq_cyc[1], 3);
            check("slt_owner", gq_idx[2], 1);
        end
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
